// File: rtl/sensor_frontend.sv
// Sensor front end: 2-flop synchronizers and per-bit debouncers for the contacts,
// plus a sliding-window temperature averager. Optional macro SENSOR_FRONTEND_TEMP_HYST_EN
// adds a +/-1 degree dead band to temperature updates once the average is valid.
module sensor_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TEMP_AVG_LOG2   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] raw_sensors,
  input  logic [5:0] adc_temp,
  input  logic       adc_valid,
  output logic [3:0] sensors,
  output logic [5:0] temp,
  output logic       temp_valid,
  output logic       change_pulse
);

  localparam int unsigned DEPTH  = 1 << TEMP_AVG_LOG2;
  localparam int unsigned SUM_W  = 6 + TEMP_AVG_LOG2;
  localparam int unsigned FILL_W = TEMP_AVG_LOG2 + 1;

  logic [3:0]               sync1_q, sync2_q;
  logic [3:0]               cnt_q [4];
  logic [3:0]               cnt_d [4];
  logic [3:0]               sensors_q, sensors_d;

  logic [5:0]               win_q [DEPTH];
  logic [TEMP_AVG_LOG2-1:0] ptr_q;
  logic [SUM_W-1:0]         sum_q, sum_d;
  logic [FILL_W-1:0]        fill_q;
  logic                     acc_q;
  logic [5:0]               temp_q, temp_d;
  logic                     tvalid_q, tvalid_d;
  logic                     pulse_q;
  logic [5:0]               avg;
  logic                     full;

  // The counter reaching DEBOUNCE_CYCLES on this edge flips the level and clears.
  always_comb begin
    sensors_d = sensors_q;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != sensors_q[i]) begin
        if (cnt_q[i] == 4'(DEBOUNCE_CYCLES - 1))
          sensors_d[i] = ~sensors_q[i];
        else
          cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  // Modular arithmetic: the intermediate may wrap but the final sum always fits.
  always_comb begin
    sum_d = sum_q + SUM_W'(adc_temp) - SUM_W'(win_q[ptr_q]);
  end

  assign avg  = 6'(sum_q >> TEMP_AVG_LOG2);
  assign full = (fill_q == FILL_W'(DEPTH));

  always_comb begin
    temp_d   = temp_q;
    tvalid_d = tvalid_q;
    if (acc_q && full) begin
      tvalid_d = 1'b1;
`ifdef SENSOR_FRONTEND_TEMP_HYST_EN
      if (!tvalid_q)
        temp_d = avg;
      else if (((avg > temp_q) ? (avg - temp_q) : (temp_q - avg)) >= 6'd2)
        temp_d = avg;
`else
      temp_d = avg;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sensors_q <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) win_q[i] <= '0;
      ptr_q     <= '0;
      sum_q     <= '0;
      fill_q    <= '0;
      acc_q     <= 1'b0;
      temp_q    <= 6'd15;
      tvalid_q  <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      sync1_q   <= raw_sensors;
      sync2_q   <= sync1_q;
      sensors_q <= sensors_d;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      if (adc_valid) begin
        win_q[ptr_q] <= adc_temp;
        ptr_q        <= ptr_q + TEMP_AVG_LOG2'(1);
        sum_q        <= sum_d;
        if (!full) fill_q <= fill_q + FILL_W'(1);
      end
      acc_q    <= adc_valid;
      temp_q   <= temp_d;
      tvalid_q <= tvalid_d;
      pulse_q  <= (sensors_d != sensors_q) || (temp_d != temp_q);
    end
  end

  assign sensors      = sensors_q;
  assign temp         = temp_q;
  assign temp_valid   = tvalid_q;
  assign change_pulse = pulse_q;

endmodule

// File: tb/tb_sensor_frontend.sv
// Directed bench for sensor_frontend at default parameters; the dead-band section
// follows SENSOR_FRONTEND_TEMP_HYST_EN so both builds are checked.
module tb_sensor_frontend;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw_sensors;
  logic [5:0] adc_temp;
  logic       adc_valid;
  logic [3:0] sensors;
  logic [5:0] temp;
  logic       temp_valid;
  logic       change_pulse;

  int vecs = 0;
  int miscompares = 0;

  sensor_frontend #(.DEBOUNCE_CYCLES(4), .TEMP_AVG_LOG2(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .raw_sensors  (raw_sensors),
    .adc_temp     (adc_temp),
    .adc_valid    (adc_valid),
    .sensors      (sensors),
    .temp         (temp),
    .temp_valid   (temp_valid),
    .change_pulse (change_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_temp(input string tag, input logic [5:0] t, input logic v);
    chk({tag, "_temp"}, 8'(temp), 8'(t));
    chk({tag, "_valid"}, 8'(temp_valid), 8'(v));
  endtask

  task automatic sample(input logic [5:0] v);
    adc_valid = 1'b1;
    adc_temp  = v;
    tick();
    adc_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; raw_sensors = '0; adc_temp = '0; adc_valid = 1'b0;
    tick(); tick();
    chk("rst_sensors", 8'(sensors), 8'd0);
    chk_temp("rst", 6'd15, 1'b0);
    chk("rst_pulse", 8'(change_pulse), 8'd0);
    rst = 1'b0;
    tick();
    chk("idle_sensors", 8'(sensors), 8'd0);

    // Stable raw change: sensors[0] appears 6 edges later with a single pulse.
    raw_sensors = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("deb_sensors", 8'(sensors), (k >= 6) ? 8'd1 : 8'd0);
      chk("deb_pulse", 8'(change_pulse), (k == 6) ? 8'd1 : 8'd0);
    end

    // Three-cycle glitch on bit 2 never gets through.
    raw_sensors = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("glitch_sensors", 8'(sensors), 8'd1);
      chk("glitch_pulse", 8'(change_pulse), 8'd0);
    end
    raw_sensors = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("glitch_sensors", 8'(sensors), 8'd1);
      chk("glitch_pulse", 8'(change_pulse), 8'd0);
    end

    // Window fill 20,22,24,26 -> 23 one edge after the fourth sample.
    sample(6'd20); chk_temp("fill1", 6'd15, 1'b0);
    sample(6'd22); chk_temp("fill2", 6'd15, 1'b0);
    sample(6'd24); chk_temp("fill3", 6'd15, 1'b0);
    sample(6'd26); chk_temp("fill4", 6'd15, 1'b0);
    tick();
    chk_temp("avg23", 6'd23, 1'b1);
    chk("avg23_pulse", 8'(change_pulse), 8'd1);
    tick();
    chk("avg23_pulse_end", 8'(change_pulse), 8'd0);
    tick(); tick();
    chk_temp("hold23", 6'd23, 1'b1);

    // 6 evicts 20: sum 78 -> 19.
    sample(6'd6);  chk_temp("s6_pre", 6'd23, 1'b1);
    tick();
    chk_temp("s6", 6'd19, 1'b1);
    chk("s6_pulse", 8'(change_pulse), 8'd1);

    // Back-to-back 63s: 119/4, 158/4, 195/4, 252/4.
    adc_valid = 1'b1; adc_temp = 6'd63;
    tick(); chk_temp("max0", 6'd19, 1'b1);
    tick(); chk_temp("max1", 6'd29, 1'b1);
    tick(); chk_temp("max2", 6'd39, 1'b1);
    tick(); chk_temp("max3", 6'd48, 1'b1);
    for (int k = 0; k < 4; k++) tick();
    adc_valid = 1'b0;
    tick(); chk_temp("max4", 6'd63, 1'b1);
    tick(); chk_temp("max_hold", 6'd63, 1'b1);

    // Partial debounce on bit 1, then reset with a sample offered in the reset cycle.
    raw_sensors = 4'b0011;
    tick(); tick(); tick();
    rst = 1'b1; raw_sensors = '0; adc_valid = 1'b1; adc_temp = 6'd50;
    tick();
    chk("mrst_sensors", 8'(sensors), 8'd0);
    chk_temp("mrst", 6'd15, 1'b0);
    chk("mrst_pulse", 8'(change_pulse), 8'd0);
    rst = 1'b0; adc_temp = 6'd20;
    tick();
    adc_temp = 6'd22; tick();
    adc_temp = 6'd24; tick();
    adc_valid = 1'b0;
    tick();
    chk_temp("refill3", 6'd15, 1'b0);
    chk("refill_sensors", 8'(sensors), 8'd0);
    sample(6'd26);
    tick();
    chk_temp("refill4", 6'd23, 1'b1);
    chk("refill_pulse", 8'(change_pulse), 8'd1);
    tick();

    // 24 evicts 20 -> avg 24; then 26 evicts 22 -> avg 25.
    sample(6'd24);
    tick();
`ifdef SENSOR_FRONTEND_TEMP_HYST_EN
    chk_temp("hyst24", 6'd23, 1'b1);
    chk("hyst24_pulse", 8'(change_pulse), 8'd0);
`else
    chk_temp("avg24", 6'd24, 1'b1);
    chk("avg24_pulse", 8'(change_pulse), 8'd1);
`endif
    tick();
    sample(6'd26);
    tick();
    chk_temp("avg25", 6'd25, 1'b1);
    chk("avg25_pulse", 8'(change_pulse), 8'd1);
    tick();
    chk("avg25_pulse_end", 8'(change_pulse), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
